// File: rtl/sid_envelope_gen.sv
// SID-style ADSR envelope generator: a 15-bit rate counter (with the wrap-around "ADSR bug"),
// an exponential decay/release divider and a zero-freeze, advanced by a per-cycle tick enable.
module sid_envelope_gen #(
   parameter int RATE_W      = 15,
   parameter bit ZERO_FREEZE = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       gate,
   input  logic [3:0] attack,
   input  logic [3:0] decay,
   input  logic [3:0] sustain,
   input  logic [3:0] release_rate,
   output logic [7:0] envelope_o,
   output logic [1:0] state_o
);

   typedef enum logic [1:0] {
      ST_ATTACK        = 2'd0,
      ST_DECAY_SUSTAIN = 2'd1,
      ST_RELEASE       = 2'd2
   } state_t;

   state_t              state;
   logic [RATE_W-1:0]   rate_cnt;
   logic [4:0]          exp_cnt;
   logic                gate_prev;
   logic                hold_zero;
   logic [7:0]          envelope;

   state_t              state_nxt;
   logic [3:0]          rate_idx;
   logic [RATE_W-1:0]   rate_period;
   logic [RATE_W-1:0]   rate_inc;
   logic                rate_step;
   logic [4:0]          exp_period;
   logic [4:0]          exp_inc;
   logic                exp_step;
   logic                gate_rise;
   logic                gate_fall;
   logic [7:0]          sustain_level;

   function automatic logic [RATE_W-1:0] period_of(input logic [3:0] idx);
      case (idx)
         4'd0:    return RATE_W'(9);
         4'd1:    return RATE_W'(32);
         4'd2:    return RATE_W'(63);
         4'd3:    return RATE_W'(95);
         4'd4:    return RATE_W'(149);
         4'd5:    return RATE_W'(220);
         4'd6:    return RATE_W'(267);
         4'd7:    return RATE_W'(313);
         4'd8:    return RATE_W'(392);
         4'd9:    return RATE_W'(977);
         4'd10:   return RATE_W'(1954);
         4'd11:   return RATE_W'(3126);
         4'd12:   return RATE_W'(3907);
         4'd13:   return RATE_W'(11720);
         4'd14:   return RATE_W'(19532);
         default: return RATE_W'(31251);
      endcase
   endfunction

   // Piecewise-linear approximation of an exponential curve: the lower the envelope, the more rate steps per decrement.
   function automatic logic [4:0] exp_period_of(input logic [7:0] env);
      if      (env > 8'h5D) return 5'd1;
      else if (env > 8'h36) return 5'd2;
      else if (env > 8'h1A) return 5'd4;
      else if (env > 8'h0E) return 5'd8;
      else if (env > 8'h06) return 5'd16;
      else                  return 5'd30;
   endfunction

   // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
   always_comb begin
      gate_rise     = gate & ~gate_prev;
      gate_fall     = ~gate & gate_prev;
      sustain_level = {sustain, sustain};
      state_nxt     = state;
      if (gate_rise)      state_nxt = ST_ATTACK;
      else if (gate_fall) state_nxt = ST_RELEASE;

      // The rate is picked from the state being entered, so a gate edge steps at the new rate on that same tick.
      case (state_nxt)
         ST_ATTACK:        rate_idx = attack;
         ST_DECAY_SUSTAIN: rate_idx = decay;
         default:          rate_idx = release_rate;
      endcase
      rate_period = period_of(rate_idx);
      rate_inc    = rate_cnt + RATE_W'(1);
      rate_step   = (rate_inc == rate_period);
      exp_period  = exp_period_of(envelope);
      exp_inc     = exp_cnt + 5'd1;
      exp_step    = (exp_inc == exp_period);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_RELEASE;
         rate_cnt  <= '0;
         exp_cnt   <= '0;
         gate_prev <= 1'b0;
         hold_zero <= 1'b1;
         envelope  <= 8'h00;
      end else if (tick) begin
         gate_prev <= gate;
         state     <= state_nxt;
         if (gate_rise) hold_zero <= 1'b0;

         if (!rate_step) begin
            // A period lowered below rate_cnt makes the counter run all the way round the wrap point.
            rate_cnt <= rate_inc;
         end else begin
            rate_cnt <= '0;
            case (state_nxt)
               ST_ATTACK: begin
                  exp_cnt <= '0;
                  if (envelope != 8'hFF) envelope <= envelope + 8'd1;
                  if (envelope >= 8'hFE) state <= ST_DECAY_SUSTAIN;
               end
               ST_DECAY_SUSTAIN: begin
                  if (exp_step) begin
                     exp_cnt <= '0;
                     if (envelope != sustain_level && envelope != 8'h00)
                        envelope <= envelope - 8'd1;
                  end else begin
                     exp_cnt <= exp_inc;
                  end
               end
               default: begin
                  if (exp_step) begin
                     exp_cnt <= '0;
                     if (!hold_zero && envelope != 8'h00) begin
                        envelope <= envelope - 8'd1;
                        if (envelope == 8'h01 && ZERO_FREEZE) hold_zero <= 1'b1;
                     end
                  end else begin
                     exp_cnt <= exp_inc;
                  end
               end
            endcase
         end
      end
   end

   assign envelope_o = envelope;
   assign state_o    = state;

endmodule
